// File: rtl/fifo_pkg.sv
// Shared definitions for the wide/narrow packing FIFO family: lane ratio,
// lane-select offset and count-width helpers.
package fifo_pkg;

  localparam int unsigned RATIO  = 8;
  localparam int unsigned BEAT_W = $clog2(RATIO);

  // Bit offset of the lane returned for a given beat; beat 0 is the MSB lane.
  function automatic int unsigned lane_lsb(input logic [BEAT_W-1:0] beat,
                                           input int unsigned       wout);
    return (RATIO - 1 - 32'(beat)) * wout;
  endfunction

  // Word count must represent 0..DEPTH inclusive.
  function automatic int unsigned wcount_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Beat count must represent 0..RATIO*DEPTH inclusive.
  function automatic int unsigned rcount_w(input int unsigned depth);
    return $clog2(depth) + BEAT_W + 1;
  endfunction

endpackage

// File: rtl/fifo_ctrl.sv
// Pointer, beat-index and occupancy control for the 256-to-32 downsizing FIFO.
// Counts and flags are registered from the post-edge occupancy.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic                          rd_en,
  output logic                          wr_accept_c,
  output logic                          rd_accept_c,
  output logic [$clog2(DEPTH)-1:0]      wr_ptr,
  output logic [$clog2(DEPTH)-1:0]      rd_ptr,
  output logic [BEAT_W-1:0]             beat,
  output logic [wcount_w(DEPTH)-1:0]    wr_count,
  output logic [rcount_w(DEPTH)-1:0]    rd_count,
  output logic                          full,
  output logic                          empty,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned WCW = wcount_w(DEPTH);
  localparam int unsigned RCW = rcount_w(DEPTH);

  logic              word_done_c;
  logic [WCW-1:0]    wr_count_nxt;
  logic [RCW-1:0]    rd_count_nxt;
  logic [BEAT_W-1:0] beat_nxt;

  // Flags are the pre-edge view: a same-cycle free or fill never rescues a request.
  assign wr_accept_c = wr_en && !full;
  assign rd_accept_c = rd_en && !empty;
  assign word_done_c = rd_accept_c && (beat == BEAT_W'(RATIO - 1));

  always_comb begin
    wr_count_nxt = wr_count;
    beat_nxt     = beat;
    if (wr_accept_c && !word_done_c) begin
      wr_count_nxt = wr_count + WCW'(1);
    end else if (!wr_accept_c && word_done_c) begin
      wr_count_nxt = wr_count - WCW'(1);
    end
    if (rd_accept_c) begin
      beat_nxt = beat + BEAT_W'(1);
    end
    // A partially read word still counts as stored; its consumed beats are subtracted.
    rd_count_nxt = RCW'({wr_count_nxt, BEAT_W'(0)}) - RCW'(beat_nxt);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      beat      <= '0;
      wr_count  <= '0;
      rd_count  <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_accept_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (word_done_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      beat      <= beat_nxt;
      wr_count  <= wr_count_nxt;
      rd_count  <= rd_count_nxt;
      full      <= (wr_count_nxt == WCW'(DEPTH));
      empty     <= (rd_count_nxt == '0);
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end

  // Occupancy invariants.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (wr_count <= WCW'(DEPTH));
      assert (rd_count <= RCW'(RATIO * DEPTH));
      assert (!(full && empty));
    end
  end

endmodule

// File: rtl/fifo_wide_to_narrow.sv
// Single-clock FIFO taking WIN-bit words and returning them as RATIO
// WOUT-bit beats, MSB lane first, with a one-cycle registered read.
module fifo_wide_to_narrow
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIN   = 256,
  parameter int unsigned WOUT  = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [WIN-1:0]                din,
  input  logic                          wr_en,
  input  logic                          rd_en,
  output logic [WOUT-1:0]               dout,
  output logic                          valid,
  output logic                          full,
  output logic                          empty,
  output logic [wcount_w(DEPTH)-1:0]    wr_count,
  output logic [rcount_w(DEPTH)-1:0]    rd_count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned SEL_W = $clog2(WIN);

  if (WIN != RATIO * WOUT) begin : g_bad_width
    $error("fifo_wide_to_narrow: WIN must equal RATIO*WOUT");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fifo_wide_to_narrow: DEPTH must be a power of two >= 2");
  end

  logic              wr_accept_c;
  logic              rd_accept_c;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [BEAT_W-1:0] beat;
  logic [WIN-1:0]    mem [DEPTH];
  logic [WIN-1:0]    word_c;
  logic [SEL_W-1:0]  lane_c;

  fifo_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .wr_accept_c (wr_accept_c),
    .rd_accept_c (rd_accept_c),
    .wr_ptr      (wr_ptr),
    .rd_ptr      (rd_ptr),
    .beat        (beat),
    .wr_count    (wr_count),
    .rd_count    (rd_count),
    .full        (full),
    .empty       (empty),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  // Storage is intentionally left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (wr_accept_c) begin
      mem[wr_ptr] <= din;
    end
  end

  always_comb begin
    word_c = mem[rd_ptr];
    lane_c = SEL_W'(lane_lsb(beat, WOUT));
  end

  // dout holds its last beat whenever no read is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout  <= '0;
      valid <= 1'b0;
    end else begin
      valid <= rd_accept_c;
      if (rd_accept_c) begin
        dout <= word_c[lane_c +: WOUT];
      end
    end
  end

endmodule
